ysyx_25040105_inst_sram: RTL and testbench

//  Instruction-memory responder for the core's fetch path: accepts one fetch request (pc) at a time,

---
 rtl/ysyx_25040105_inst_sram.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_25040105_inst_sram.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040105_inst_sram.sv
// ----------------------------------------------------------------------------
// ysyx_25040105_inst_sram
//
// Instruction-memory responder for the core's fetch path. It accepts one fetch
// request at a time and returns the addressed 32-bit word LATENCY cycles after
// acceptance over a valid/ready response channel. A side port preloads the
// word-addressed array, and that port can write in any cycle.
//
// Ports
//   clk        in   1   sole clock, all state updates on posedge
//   rst        in   1   synchronous, active-high reset
//   req_valid  in   1   fetch request valid
//   req_ready  out  1   high only while idle
//   req_addr   in   32  fetch byte address (pc)
//   rsp_valid  out  1   response valid (registered)
//   rsp_ready  in   1   initiator accepts response
//   rsp_data   out  32  instruction word, or ebreak on error (registered)
//   rsp_err    out  1   misaligned or out-of-range fetch address (registered)
//   load_wen   in   1   preload write enable
//   load_addr  in   32  preload byte address, same map as req_addr
//   load_data  in   32  preload word
//
// Configuration macro
//   RAND_DELAY_EN : when defined, an 8-bit LFSR adds 0..3 extra cycles of
//                   latency to each accepted request.
// ----------------------------------------------------------------------------
module ysyx_25040105_inst_sram #(
    parameter int unsigned DEPTH    = 4096,
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter int unsigned LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        load_wen,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [4:0]  LAT5   = 5'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word index relative to MEM_BASE. The subtraction wraps, so addresses
    // below the base land far above DEPTH and are reported as out of range.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return (addr - MEM_BASE) >> 2;
    endfunction

    // An address is unusable if it is misaligned or if it falls outside the array.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] idx);
        return (addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));
    endfunction

    logic [31:0] mem [DEPTH];

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  cnt_r;
    logic [4:0]  cnt_s;
    logic [31:0] addr_r;
    logic        accept_s;
    logic        capture_s;
    logic [4:0]  eff_lat_s;

    logic [31:0] fetch_addr_s;
    logic [31:0] fetch_idx_s;
    logic        fetch_bad_s;
    logic [31:0] rd_word_s;
    logic [31:0] load_idx_s;
    logic        load_bad_s;

`ifdef RAND_DELAY_EN
    logic [7:0] lfsr_r;

    // Free-running Fibonacci LFSR for x^8+x^6+x^5+x^4+1, reseeded by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    assign eff_lat_s = LAT5 + {3'b000, lfsr_r[1:0]};
`else
    assign eff_lat_s = LAT5;
`endif

    assign req_ready = (state_r == IDLE);

    // Address decode for the fetch and preload ports. A single-cycle capture
    // happens on the accept edge, so the fetch address comes directly from
    // req_addr while idle.
    always_comb begin
        if (state_r == IDLE) begin
            fetch_addr_s = req_addr;
        end else begin
            fetch_addr_s = addr_r;
        end
        fetch_idx_s = word_index(fetch_addr_s);
        fetch_bad_s = addr_bad(fetch_addr_s, fetch_idx_s);
        if (fetch_bad_s) begin
            rd_word_s = EBREAK;
        end else begin
            rd_word_s = mem[fetch_idx_s[AW-1:0]];
        end
        load_idx_s = word_index(load_addr);
        load_bad_s = addr_bad(load_addr, load_idx_s);
    end

    // Next-state logic: accept while idle, count down the latency, then hold the response until it is taken.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (eff_lat_s == 5'd1) begin
                        state_s   = RESP;
                        capture_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = eff_lat_s - 5'd1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 5'd1) begin
                    state_s   = RESP;
                    capture_s = 1'b1;
                end else begin
                    state_s = WAIT;
                    cnt_s   = cnt_r - 5'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter, latched address and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 5'd0;
            addr_r    <= 32'h0000_0000;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rsp_valid <= (state_s == RESP);
            if (accept_s) begin
                addr_r <= req_addr;
            end
            // The read is combinational from the array, so a preload on this
            // same edge is not seen and the old word is captured.
            if (capture_s) begin
                rsp_data <= rd_word_s;
                rsp_err  <= fetch_bad_s;
            end
        end
    end

    // Preload port. The array has no reset, and bad addresses are dropped.
    always_ff @(posedge clk) begin
        if (load_wen && !load_bad_s) begin
            mem[load_idx_s[AW-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_inst_sram.sv
// Bench for ysyx_25040105_inst_sram. It uses two instances: LATENCY=1 and LATENCY=3.
// A transaction-level reference model predicts every output after every clock edge.
module tb_ysyx_25040105_inst_sram;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [2];
    logic        rsp_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_data  [2];
    logic        load_wen;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    ysyx_25040105_inst_sram #(.DEPTH(4096), .MEM_BASE(32'h8000_0000), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .load_wen(load_wen), .load_addr(load_addr), .load_data(load_data)
    );

    ysyx_25040105_inst_sram #(.DEPTH(4096), .MEM_BASE(32'h8000_0000), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .load_wen(load_wen), .load_addr(load_addr), .load_data(load_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat [2] = '{1, 3};

    // Reference model state for each instance.
    bit          m_busy [2];
    bit          m_resp [2];
    bit          m_show [2];
    logic [31:0] m_data [2];
    logic        m_err  [2];
    logic [31:0] m_addr [2];
    int          m_due  [2];
    logic [31:0] ref_mem [4096];

    vec_t vecs [8];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic bit ref_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= 32'h0000_4000);
    endfunction

    function automatic logic [11:0] ref_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) / 32'd4;
        return off[11:0];
    endfunction

    task automatic capture(input int i);
        if (ref_bad(m_addr[i])) begin
            m_data[i] = EBREAK;
            m_err[i]  = 1'b1;
        end else begin
            m_data[i] = ref_mem[ref_idx(m_addr[i])];
            m_err[i]  = 1'b0;
        end
        m_resp[i] = 1'b1;
        m_busy[i] = 1'b0;
        m_show[i] = 1'b1;
    endtask

    // Advance the model over one edge, clock the DUTs, then compare the outputs.
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_resp[i] = 1'b0;
                m_data[i] = 32'h0;
                m_err[i]  = 1'b0;
                m_show[i] = 1'b1;
            end else if (m_resp[i]) begin
                if (rsp_ready[i]) begin
                    m_resp[i] = 1'b0;
                    m_show[i] = 1'b0;
                end
            end else if (m_busy[i]) begin
                if (cyc == m_due[i]) capture(i);
            end else if (req_valid[i]) begin
                m_addr[i] = req_addr[i];
                m_due[i]  = cyc + lat[i] - 1;
                if (lat[i] == 1) capture(i);
                else m_busy[i] = 1'b1;
            end
        end
        if (load_wen && !ref_bad(load_addr)) ref_mem[ref_idx(load_addr)] = load_data;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("req_ready", i, 32'(req_ready[i]), 32'(!(m_busy[i] || m_resp[i])));
            chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(m_resp[i]));
            if (m_show[i]) begin
                chk("rsp_data", i, rsp_data[i], m_data[i]);
                chk("rsp_err", i, 32'(rsp_err[i]), 32'(m_err[i]));
            end
        end
    endtask

    task automatic drain(input int i);
        rsp_ready[i] = 1'b1;
        step();
        rsp_ready[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_w;
        int r;

        rst = 1'b1;
        load_wen = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
            req_addr[i]  = BASE;
            m_busy[i] = 1'b0;
            m_resp[i] = 1'b0;
            m_show[i] = 1'b1;
            m_data[i] = 32'h0;
            m_err[i]  = 1'b0;
            m_addr[i] = 32'h0;
            m_due[i]  = 0;
        end

        vecs[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h00A0_0513, 1'b0};
        vecs[2] = '{32'h8000_3FFC, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{32'h8000_0002, EBREAK,        1'b1};
        vecs[4] = '{32'h8000_4000, EBREAK,        1'b1};
        vecs[5] = '{32'h7FFF_FFFC, EBREAK,        1'b1};
        vecs[6] = '{32'h0000_0000, EBREAK,        1'b1};
        vecs[7] = '{32'hFFFF_FFFD, EBREAK,        1'b1};

        // Reset for two cycles, with explicit reset values.
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(req_ready[i]), 32'd1);
            chk("rst_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("rst_data", i, rsp_data[i], 32'h0);
            chk("rst_err", i, 32'(rsp_err[i]), 32'd0);
        end
        rst = 1'b0;

        // Preload words 0..63 and the last word, then two loads that must be dropped.
        load_wen = 1'b1;
        for (int w = 0; w < 64; w++) begin
            load_addr = BASE + 32'(w * 4);
            load_data = (w == 0) ? 32'h0000_0413 : (w == 1) ? 32'h00A0_0513 : $urandom;
            step();
        end
        load_addr = BASE + 32'h0000_3FFC; load_data = 32'hDEAD_BEEF; step();
        load_addr = BASE + 32'h0000_4000; load_data = 32'h1111_1111; step();
        load_addr = BASE + 32'h0000_0002; load_data = 32'h2222_2222; step();
        load_wen = 1'b0;

        // Fixed-vector table on the LATENCY=1 instance.
        for (int k = 0; k < 8; k++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = vecs[k].addr;
            step();
            req_valid[0] = 1'b0;
            chk("vec_valid", k, 32'(rsp_valid[0]), 32'd1);
            chk("vec_data", k, rsp_data[0], vecs[k].data);
            chk("vec_err", k, 32'(rsp_err[0]), 32'(vecs[k].err));
            drain(0);
        end

        // LATENCY=3 timing and hold under backpressure.
        exp_w = ref_mem[2];
        req_valid[1] = 1'b1; req_addr[1] = BASE + 32'h8; step(); req_valid[1] = 1'b0;
        chk("lat3_v1", 1, 32'(rsp_valid[1]), 32'd0);
        chk("lat3_r1", 1, 32'(req_ready[1]), 32'd0);
        step();
        chk("lat3_v2", 1, 32'(rsp_valid[1]), 32'd0);
        step();
        chk("lat3_v3", 1, 32'(rsp_valid[1]), 32'd1);
        chk("lat3_d3", 1, rsp_data[1], exp_w);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_valid", 1, 32'(rsp_valid[1]), 32'd1);
            chk("hold_data", 1, rsp_data[1], exp_w);
            chk("hold_ready", 1, 32'(req_ready[1]), 32'd0);
        end
        drain(1);
        chk("after_hs_ready", 1, 32'(req_ready[1]), 32'd1);

        // A load during WAIT is visible to the fetch, and a load on the RESP-entry edge is not.
        req_valid[1] = 1'b1; req_addr[1] = BASE + 32'hC; step(); req_valid[1] = 1'b0;
        load_wen = 1'b1; load_addr = BASE + 32'hC; load_data = 32'hCAFE_0001; step(); load_wen = 1'b0;
        step();
        chk("wait_load", 1, rsp_data[1], 32'hCAFE_0001);
        drain(1);
        req_valid[1] = 1'b1; step(); req_valid[1] = 1'b0;
        step();
        load_wen = 1'b1; load_data = 32'hCAFE_0002; step(); load_wen = 1'b0;
        chk("entry_load_old", 1, rsp_data[1], 32'hCAFE_0001);
        drain(1);
        req_valid[1] = 1'b1; step(); req_valid[1] = 1'b0;
        step(); step();
        chk("entry_load_new", 1, rsp_data[1], 32'hCAFE_0002);
        drain(1);

        // Reset in WAIT drops the request, and the array keeps its contents.
        req_valid[1] = 1'b1; req_addr[1] = BASE + 32'h10; step(); req_valid[1] = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstw_valid", 1, 32'(rsp_valid[1]), 32'd0);
        chk("rstw_ready", 1, 32'(req_ready[1]), 32'd1);
        step(); step();
        chk("rstw_novalid", 1, 32'(rsp_valid[1]), 32'd0);
        exp_w = ref_mem[4];
        req_valid[1] = 1'b1; step(); req_valid[1] = 1'b0;
        step(); step();
        chk("refetch", 1, rsp_data[1], exp_w);
        drain(1);

        // Randomized traffic checked against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
                r = int'($urandom_range(0, 9));
                if (r == 0)      req_addr[i] = $urandom | 32'h1;
                else if (r == 1) req_addr[i] = $urandom & 32'h7FFF_FFFC;
                else if (r == 2) req_addr[i] = BASE + 32'h3FFC;
                else             req_addr[i] = BASE + 32'($urandom_range(0, 63) * 4);
            end
            load_wen  = ($urandom_range(0, 4) == 0);
            r = int'($urandom_range(0, 7));
            if (r == 0)      load_addr = $urandom | 32'h2;
            else if (r == 1) load_addr = $urandom & 32'h7FFF_FFFC;
            else             load_addr = BASE + 32'($urandom_range(0, 63) * 4);
            load_data = $urandom;
            step();
        end

        rst = 1'b0;
        load_wen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b1;
        end
        for (int k = 0; k < 6; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
